// File: rtl/mem_bus_arb_pkg.sv
// Shared types and geometry helpers for the I/D memory bus arbiter.
package mem_bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_XFER = 2'd1,
    D_XFER = 2'd2
  } arb_state_t;

  function automatic int unsigned beat_bytes(input int unsigned data_w);
    return data_w / 8;
  endfunction

  function automatic int unsigned beat_off(input int unsigned data_w);
    return $clog2(data_w / 8);
  endfunction

  function automatic int unsigned line_off(input int unsigned data_w, input int unsigned line_beats);
    return $clog2(line_beats * data_w / 8);
  endfunction

  function automatic int unsigned cnt_w(input int unsigned line_beats);
    return $clog2(line_beats);
  endfunction

endpackage

// File: rtl/mem_bus_arb_if.sv
// Shared memory bus: one beat request/ack handshake with read and write data.
interface mem_bus_arb_if #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
);
  logic              b_req;
  logic              b_we;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic              b_ack;
  logic [DATA_W-1:0] b_rdata;

  modport master (output b_req, b_we, b_addr, b_wdata, input b_ack, b_rdata);
  modport slave  (input b_req, b_we, b_addr, b_wdata, output b_ack, b_rdata);
endinterface

// File: rtl/mem_bus_arb_bus_beat_gen.sv
// Beat counter, last-beat flag and incrementing beat address within a cache line.
module bus_beat_gen
  import mem_bus_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 64,
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned LINE_BEATS = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              active,
  input  logic              ack,
  input  logic [ADDR_W-1:0] base,
  output logic              last,
  output logic [ADDR_W-1:0] addr
);

  localparam int unsigned CW   = cnt_w(LINE_BEATS);
  localparam int unsigned BOFF = beat_off(DATA_W);
  localparam int unsigned OFF  = line_off(DATA_W, LINE_BEATS);

  logic [CW-1:0] cnt;
  logic          unused_ok;

  assign last = (cnt == CW'(LINE_BEATS - 1));

  always_ff @(posedge clk) begin
    if (!rst_n)
      cnt <= '0;
    else if (active && ack)
      cnt <= last ? '0 : cnt + 1'b1;
  end

  // line offset bits of the request address are replaced by the beat index
  assign addr      = {base[ADDR_W-1:OFF], cnt, {BOFF{1'b0}}};
  assign unused_ok = ^base[OFF-1:0];

endmodule

// File: rtl/mem_bus_arb.sv
// I/D cache line arbiter for the shared memory bus, with D write-back and AMO bus lock.
module mem_bus_arb
  import mem_bus_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 64,
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned LINE_BEATS = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic              i_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic              d_wnext,
  output logic              d_done,
  input  logic              amo_req,
  output logic              amo_ack,
  mem_bus_arb_if.master     bus,
  output logic              b_rd_i,
  output logic              b_rd_d
);

  arb_state_t        state, state_nx;
  logic              grant_i, grant_d;
  logic              last_d, lock_q, we_q;
  logic              i_gnt_q, d_gnt_q;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] beat_addr;
  logic              in_xfer, last_beat, beat_done;
  logic              is_i, is_d;

  assign is_i      = (state == I_XFER);
  assign is_d      = (state == D_XFER);
  assign in_xfer   = is_i || is_d;
  assign beat_done = in_xfer && bus.b_ack && last_beat;

  always_ff @(posedge clk) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nx;
  end

  // D wins unless I is waiting and D had the last turn, or D is idle; the lock bars I
  always_comb begin
    state_nx = state;
    grant_i  = 1'b0;
    grant_d  = 1'b0;
    case (state)
      IDLE: begin
        grant_i = i_req && !lock_q && (last_d || !d_req);
        grant_d = d_req && (lock_q || !(i_req && last_d));
        if (grant_d)
          state_nx = D_XFER;
        else if (grant_i)
          state_nx = I_XFER;
      end
      I_XFER, D_XFER: if (beat_done) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_d  <= 1'b0;
      lock_q  <= 1'b0;
      we_q    <= 1'b0;
      base_q  <= '0;
      i_gnt_q <= 1'b0;
      d_gnt_q <= 1'b0;
    end else begin
      i_gnt_q <= grant_i;
      d_gnt_q <= grant_d;
      if (grant_i) begin
        last_d <= 1'b0;
        base_q <= i_addr;
        we_q   <= 1'b0;
      end else if (grant_d) begin
        last_d <= 1'b1;
        base_q <= d_addr;
        we_q   <= d_we;
      end
      if (!amo_req)
        lock_q <= 1'b0;
      else if (state == IDLE || beat_done)
        lock_q <= 1'b1;
    end
  end

  bus_beat_gen #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .LINE_BEATS(LINE_BEATS)
  ) u_beat (
    .clk   (clk),
    .rst_n (rst_n),
    .active(in_xfer),
    .ack   (bus.b_ack),
    .base  (base_q),
    .last  (last_beat),
    .addr  (beat_addr)
  );

  assign i_gnt       = i_gnt_q;
  assign d_gnt       = d_gnt_q;
  assign bus.b_req   = in_xfer;
  assign bus.b_we    = is_d && we_q;
  assign bus.b_addr  = beat_addr;
  assign bus.b_wdata = d_wdata;
  assign i_rvalid    = bus.b_ack && is_i && !we_q;
  assign d_rvalid    = bus.b_ack && is_d && !we_q;
  assign d_wnext     = bus.b_ack && is_d && we_q;
  assign i_done      = bus.b_ack && is_i && last_beat;
  assign d_done      = bus.b_ack && is_d && last_beat;
  assign amo_ack     = lock_q;
  assign b_rd_i      = is_i;
  assign b_rd_d      = is_d && !we_q;

endmodule

// File: tb/tb_mem_bus_arb.sv
// Directed scoreboard bench for mem_bus_arb: expected transfers queued with stimulus, checked beat by beat.
module tb_mem_bus_arb;

  localparam int unsigned AW = 64;
  localparam int unsigned DW = 64;
  localparam int unsigned NB = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_req, d_req, d_we, amo_req;
  logic [AW-1:0] i_addr, d_addr;
  logic [DW-1:0] d_wdata;
  logic          i_gnt, i_rvalid, i_done;
  logic          d_gnt, d_rvalid, d_wnext, d_done;
  logic          amo_ack, b_rd_i, b_rd_d;

  always #5 clk = ~clk;

  mem_bus_arb_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_bus_arb #(.ADDR_W(AW), .DATA_W(DW), .LINE_BEATS(NB)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_wnext(d_wnext), .d_done(d_done),
    .amo_req(amo_req), .amo_ack(amo_ack),
    .bus(bus),
    .b_rd_i(b_rd_i), .b_rd_d(b_rd_d)
  );

  typedef struct { bit d; logic [63:0] base; bit we; } xfer_t;
  typedef struct { logic [63:0] addr; bit last; } beat_t;

  xfer_t exp_x[$];
  beat_t exp_b[$];
  xfer_t cur;
  bit    in_xfer, have_done;
  bit    ack_alt, gap_chk, drop_on_gnt, drop_on_last;
  int unsigned cyc, n_gnt, n_done, n_wnext, beats_seen, wr_idx, done_cyc;
  int n_assert = 0;
  int n_fail   = 0;

  function automatic logic [63:0] wd(input int unsigned k);
    return 64'hA5A5_0000_0000_0000 | 64'(k);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_x(input bit d, input logic [63:0] addr, input bit we);
    xfer_t x;
    x.d    = d;
    x.base = addr & ~64'h3F;
    x.we   = we;
    exp_x.push_back(x);
  endtask

  task automatic observe();
    xfer_t x;
    beat_t b;
    if (i_gnt || d_gnt) begin
      n_gnt++;
      if (exp_x.size() == 0) begin
        chk("unexp_gnt", 64'({i_gnt, d_gnt}), 64'd0);
      end else begin
        x = exp_x.pop_front();
        chk("gnt_i", 64'(i_gnt), 64'(!x.d));
        chk("gnt_d", 64'(d_gnt), 64'(x.d));
        chk("gnt_breq", 64'(bus.b_req), 64'd1);
        if (gap_chk && have_done) chk("gap", 64'(cyc - done_cyc), 64'd2);
        for (int unsigned k = 0; k < NB; k++) begin
          b.addr = x.base + 64'(8 * k);
          b.last = (k == NB - 1);
          exp_b.push_back(b);
        end
        cur        = x;
        in_xfer    = 1'b1;
        beats_seen = 0;
        if (drop_on_gnt) begin
          if (x.d) d_req = 1'b0;
          else     i_req = 1'b0;
        end
      end
    end
    chk("b_req", 64'(bus.b_req), 64'(in_xfer));
    chk("b_rd_i", 64'(b_rd_i), 64'(in_xfer && !cur.d));
    chk("b_rd_d", 64'(b_rd_d), 64'(in_xfer && cur.d && !cur.we));
    if (d_wnext) n_wnext++;
    if (bus.b_ack) begin
      if (exp_b.size() == 0) begin
        chk("unexp_ack", 64'd1, 64'd0);
      end else begin
        b = exp_b.pop_front();
        chk("b_addr", bus.b_addr, b.addr);
        chk("b_we", 64'(bus.b_we), 64'(cur.we));
        chk("i_rvalid", 64'(i_rvalid), 64'(!cur.d));
        chk("d_rvalid", 64'(d_rvalid), 64'(cur.d && !cur.we));
        chk("d_wnext", 64'(d_wnext), 64'(cur.d && cur.we));
        chk("i_done", 64'(i_done), 64'(b.last && !cur.d));
        chk("d_done", 64'(d_done), 64'(b.last && cur.d));
        if (cur.d && cur.we) begin
          chk("b_wdata", bus.b_wdata, wd(wr_idx));
          wr_idx++;
        end
        beats_seen++;
        if (b.last) begin
          in_xfer   = 1'b0;
          n_done++;
          done_cyc  = cyc;
          have_done = 1'b1;
          wr_idx    = 0;
          if (drop_on_last && exp_x.size() == 0) begin
            i_req = 1'b0;
            d_req = 1'b0;
          end
        end
      end
    end else begin
      chk("quiet", 64'({i_rvalid, d_rvalid, d_wnext, i_done, d_done}), 64'd0);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    bus.b_ack   = bus.b_req && (!ack_alt || cyc[0]);
    bus.b_rdata = bus.b_addr ^ 64'hDEAD_BEEF_0000_0000;
    d_wdata     = d_we ? wd(wr_idx) : '0;
    #1;
    observe();
  endtask

  task automatic wait_done(input int unsigned target, input int unsigned budget);
    int unsigned n = 0;
    while (n_done < target && n < budget) begin
      step();
      n++;
    end
    chk("done_cnt", 64'(n_done), 64'(target));
  endtask

  task automatic wait_gnt(input int unsigned target, input int unsigned budget);
    int unsigned n = 0;
    while (n_gnt < target && n < budget) begin
      step();
      n++;
    end
    chk("gnt_cnt", 64'(n_gnt), 64'(target));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_flags"}, 64'({i_gnt, i_rvalid, i_done, d_gnt, d_rvalid, d_wnext, d_done,
                             amo_ack, bus.b_req, bus.b_we, b_rd_i, b_rd_d}), 64'd0);
    chk({tag, "_addr"}, bus.b_addr, 64'd0);
    chk({tag, "_wdata"}, bus.b_wdata, 64'd0);
  endtask

  initial begin
    int unsigned c0, nd, n;
    rst_n = 1'b0; i_req = 1'b1; d_req = 1'b1; d_we = 1'b0; amo_req = 1'b0;
    i_addr = 64'h4000; d_addr = 64'h5000; d_wdata = '0;
    bus.b_ack = 1'b0; bus.b_rdata = '0;
    cyc = 0; n_gnt = 0; n_done = 0; n_wnext = 0; beats_seen = 0; wr_idx = 0; done_cyc = 0;
    in_xfer = 1'b0; have_done = 1'b0; cur = '{d: 1'b0, base: 64'd0, we: 1'b0};
    ack_alt = 1'b0; gap_chk = 1'b0; drop_on_gnt = 1'b0; drop_on_last = 1'b0;

    // reset, then contention with both requests held from reset
    repeat (3) step();
    chk_zero("reset");
    push_x(1, 64'h5000, 0); push_x(0, 64'h4000, 0);
    push_x(1, 64'h5000, 0); push_x(0, 64'h4000, 0);
    gap_chk = 1'b1; drop_on_last = 1'b1;
    rst_n = 1'b1;
    wait_done(4, 200);
    gap_chk = 1'b0;
    repeat (3) step();

    // solo I fill, unaligned address
    i_addr = 64'h1038;
    push_x(0, 64'h1038, 0);
    c0 = cyc;
    i_req = 1'b1;
    wait_gnt(n_gnt + 1, 10);
    chk("i_gnt_lat", 64'(cyc - c0), 64'd1);
    wait_done(n_done + 1, 40);
    repeat (3) step();

    // request dropped right after grant
    drop_on_gnt = 1'b1;
    i_addr = 64'h1240;
    push_x(0, 64'h1240, 0);
    nd = n_done;
    i_req = 1'b1;
    wait_done(nd + 1, 40);
    repeat (4) step();
    chk("drop_done_once", 64'(n_done), 64'(nd + 1));

    // write-back with acks on alternate cycles
    ack_alt = 1'b1; d_we = 1'b1; d_addr = 64'h2000;
    push_x(1, 64'h2000, 1);
    n_wnext = 0;
    d_req = 1'b1;
    wait_done(n_done + 1, 60);
    chk("wnext_cnt", 64'(n_wnext), 64'(NB));
    repeat (2) step();
    ack_alt = 1'b0; d_we = 1'b0;
    repeat (2) step();

    // AMO lock raised during an I transfer
    drop_on_gnt = 1'b0; drop_on_last = 1'b0;
    i_addr = 64'h6000;
    push_x(0, 64'h6000, 0);
    i_req = 1'b1;
    wait_gnt(n_gnt + 1, 10);
    amo_req = 1'b1; d_addr = 64'h7000; d_req = 1'b1;
    push_x(1, 64'h7000, 0); push_x(1, 64'h7000, 0);
    nd = n_done;
    step(); step();
    chk("amo_early", 64'(amo_ack), 64'd0);
    gap_chk = 1'b1;
    wait_done(nd + 1, 20);
    step();
    chk("amo_locked", 64'(amo_ack), 64'd1);
    wait_done(nd + 3, 60);
    d_req = 1'b0;
    repeat (4) step();
    chk("amo_hold", 64'(amo_ack), 64'd1);
    gap_chk = 1'b0; drop_on_last = 1'b1;
    push_x(0, 64'h6000, 0);
    amo_req = 1'b0;
    step();
    chk("amo_release", 64'(amo_ack), 64'd0);
    wait_done(nd + 4, 30);
    repeat (3) step();

    // reset on beat 3 of a D fill, then restart
    drop_on_gnt = 1'b1;
    d_addr = 64'h3000;
    push_x(1, 64'h3000, 0);
    d_req = 1'b1;
    n = 0;
    while (!(in_xfer && beats_seen == 3) && n < 20) begin
      step();
      n++;
    end
    chk("abort_reach", 64'(beats_seen), 64'd3);
    step();
    rst_n = 1'b0;
    exp_b.delete();
    in_xfer = 1'b0; wr_idx = 0; have_done = 1'b0;
    nd = n_done;
    step();
    chk_zero("abort");
    rst_n = 1'b1;
    step();
    chk("abort_no_done", 64'(n_done), 64'(nd));
    push_x(1, 64'h3000, 0);
    d_req = 1'b1;
    wait_done(nd + 1, 40);
    repeat (3) step();
    chk("sb_empty", 64'(exp_x.size() + exp_b.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
